// File: rtl/vga_pixel_scanout.sv
// vga_pixel_scanout
//   Raster scan-out stage for the pixel-clock side of the frame buffer.
//   Generates VGA horizontal/vertical timing with free-running counters and
//   pops one 24-bit pixel per visible cycle from a small skid buffer that is
//   fed by the frame-buffer FIFO. Sticky underflow/overflow status is kept
//   for software debug.
//
// Ports
//   clk              pixel clock (FIFO read-side clock)
//   reset            synchronous, active-high
//   asi_data[31:0]   pixel word: [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored
//   asi_valid        word present on asi_data
//   asi_ready        sink ready, ready latency 1
//   vga_r/g/b[7:0]   pixel colour, 0 during blanking or starvation
//   vga_hsync        horizontal sync, polarity from SYNC_ACTIVE_HIGH
//   vga_vsync        vertical sync, polarity from SYNC_ACTIVE_HIGH
//   vga_de           data enable, high on visible pixels
//   underflow_count  saturating count of visible pixels with no data
//   overflow         sticky: a word arrived while the buffer was full
//   clear_status     clears underflow_count and overflow
//
// Handshake: the source may present a word (asi_valid=1) only in the cycle
// after it saw asi_ready=1 (ready latency 1). Every asi_valid cycle is a
// transfer; the sink never back-pressures a word already in flight. To make
// that safe, asi_ready counts both stored words and the word that may still
// be in flight from last cycle's ready, and ignores same-cycle pops.

module vga_pixel_scanout #(
    parameter int H_ACTIVE         = 640,
    parameter int H_FP             = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BP             = 48,
    parameter int V_ACTIVE         = 480,
    parameter int V_FP             = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BP             = 33,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int SKID_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] asi_data,
    input  logic        asi_valid,
    output logic        asi_ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [15:0] underflow_count,
    output logic        overflow,
    input  logic        clear_status
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PTR_W   = $clog2(SKID_DEPTH);
    localparam int OCC_W   = PTR_W + 1;

    localparam logic [11:0] H_ACT_C      = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_C      = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);

    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(SKID_DEPTH);
    localparam logic             SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    // Raster position
    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic        active;
    logic        h_sync_win;
    logic        v_sync_win;

    // Skid buffer
    logic [23:0]      skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] credit;
    logic             ready_prev;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    // The alpha/pad byte is carried on the bus but has no use here.
    logic unused_hi;
    assign unused_hi = ^asi_data[31:24];

    assign active     = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    assign h_sync_win = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
    assign v_sync_win = (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);

    assign empty = (occ == '0);
    assign full  = (occ == DEPTH_C);
    assign pop   = active && !empty;
    // A full buffer still accepts a word when the head leaves this cycle.
    assign push  = asi_valid && (!full || pop);

    // Conservative credit: stored words plus the word that may arrive this
    // cycle because of last cycle's ready. Held low while in reset.
    assign credit    = occ + OCC_W'(ready_prev);
    assign asi_ready = !reset && (credit < DEPTH_C);

    // Horizontal/vertical counters. The frame starts in vertical blanking
    // so the buffer can prefill before the first visible line.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= V_ACT_C;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
        end else begin
            hcnt <= hcnt + 12'd1;
        end
    end

    // Skid buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            ready_prev <= 1'b0;
        end else begin
            ready_prev <= asi_ready;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone says what is valid. When full
    // with a pop, wr_ptr == rd_ptr and the head is read before overwrite.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            skid_mem[wr_ptr] <= asi_data[23:0];
        end
    end

    // Registered display outputs, all with the same one-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_de    <= 1'b0;
            vga_r     <= 8'h00;
            vga_g     <= 8'h00;
            vga_b     <= 8'h00;
            vga_hsync <= ~SYNC_ON;
            vga_vsync <= ~SYNC_ON;
        end else begin
            vga_de    <= active;
            {vga_r, vga_g, vga_b} <= pop ? skid_mem[rd_ptr] : 24'h000000;
            vga_hsync <= h_sync_win ? SYNC_ON : ~SYNC_ON;
            vga_vsync <= v_sync_win ? SYNC_ON : ~SYNC_ON;
        end
    end

    // Debug status; clear wins over a same-cycle event.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_count <= '0;
            overflow        <= 1'b0;
        end else begin
            if (clear_status) begin
                underflow_count <= '0;
            end else if (active && empty && (underflow_count != 16'hFFFF)) begin
                underflow_count <= underflow_count + 16'd1;
            end

            if (clear_status) begin
                overflow <= 1'b0;
            end else if (asi_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
